baud_tick_gen: RTL and testbench

Parametrised, programmable tick generator for the UART datapath and other serial blocks. A prescaler divides clk by a runtime-loadable divisor to produce an oversample tick. A second counter divides that tick by OVS to produce bit-rate and mid-bit ticks. Divisor changes are glitch-free, and a phase-sync input realigns the ticks to a received start edge.

---
 rtl/baud_tick_gen.sv | 94 +++++++++
 tb/tb_baud_tick_gen.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/baud_tick_gen.sv
// Programmable oversample/bit/mid-bit tick generator for serial datapaths.
// A prescaler divides clk by div_active; a second counter divides that tick by OVS.
module baud_tick_gen #(
  parameter int CNT_W       = 16,
  parameter int DEFAULT_DIV = 217,
  parameter int OVS         = 16,
  parameter int OVS_W       = 4
) (
  input  logic             clk,
  input  logic             s_reset_n,
  input  logic             enable,
  input  logic             div_load,
  input  logic [CNT_W-1:0] div_value,
  input  logic             phase_sync,
  output logic             ovs_tick,
  output logic             bit_tick,
  output logic             mid_tick,
  output logic [CNT_W-1:0] div_active,
  output logic             load_pending
);

  localparam logic [CNT_W-1:0] DIV_RESET = CNT_W'(DEFAULT_DIV);
  localparam logic [CNT_W-1:0] DIV_MIN   = CNT_W'(2);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [OVS_W-1:0] OCNT_LAST = OVS_W'(OVS - 1);
  localparam logic [OVS_W-1:0] OCNT_MID  = OVS_W'(OVS / 2 - 1);

  logic [CNT_W-1:0] pcnt;
  logic [CNT_W-1:0] shadow;
  logic [CNT_W-1:0] div_clamped;
  logic [OVS_W-1:0] ocnt;
  logic             rollover;

  // Divisors below 2 would make the prescaler degenerate, so they are raised to 2.
  assign div_clamped = (div_value < DIV_MIN) ? DIV_MIN : div_value;
  assign rollover    = enable && (pcnt == (div_active - CNT_ONE));

  always_ff @(posedge clk) begin
    if (!s_reset_n) begin
      pcnt <= '0;
      ocnt <= '0;
    end else if (phase_sync) begin
      pcnt <= '0;
      ocnt <= '0;
    end else if (rollover) begin
      pcnt <= '0;
      ocnt <= (ocnt == OCNT_LAST) ? '0 : ocnt + 1'b1;
    end else if (enable) begin
      pcnt <= pcnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!s_reset_n || phase_sync) begin
      ovs_tick <= 1'b0;
      bit_tick <= 1'b0;
      mid_tick <= 1'b0;
    end else begin
      ovs_tick <= rollover;
      bit_tick <= rollover && (ocnt == OCNT_LAST);
      mid_tick <= rollover && (ocnt == OCNT_MID);
    end
  end

  // New divisors only take effect at a period boundary (rollover or phase_sync),
  // so a period already in progress keeps its length.
  always_ff @(posedge clk) begin
    if (!s_reset_n) begin
      div_active   <= DIV_RESET;
      shadow       <= DIV_RESET;
      load_pending <= 1'b0;
    end else if (phase_sync) begin
      if (div_load) begin
        shadow     <= div_clamped;
        div_active <= div_clamped;
      end else if (load_pending) begin
        div_active <= shadow;
      end
      load_pending <= 1'b0;
    end else if (div_load) begin
      shadow <= div_clamped;
      if (rollover) begin
        div_active   <= div_clamped;
        load_pending <= 1'b0;
      end else begin
        load_pending <= 1'b1;
      end
    end else if (rollover && load_pending) begin
      div_active   <= shadow;
      load_pending <= 1'b0;
    end
  end

endmodule

// File: tb/tb_baud_tick_gen.sv
// Self-checking bench for baud_tick_gen: directed scenarios plus random traffic,
// every cycle compared against a tick-counting reference model.
module tb_baud_tick_gen;

  localparam int CNT_W       = 16;
  localparam int DEFAULT_DIV = 217;
  localparam int OVS         = 16;
  localparam int OVS_W       = 4;

  logic             clk = 1'b0;
  logic             s_reset_n;
  logic             enable;
  logic             div_load;
  logic [CNT_W-1:0] div_value;
  logic             phase_sync;
  logic             ovs_tick;
  logic             bit_tick;
  logic             mid_tick;
  logic [CNT_W-1:0] div_active;
  logic             load_pending;

  int checks   = 0;
  int failures = 0;

  // Reference model state: enabled clocks elapsed in the current ovs period and
  // ovs ticks issued since the last reset/phase_sync.
  int m_elapsed, m_ticks, m_div, m_shadow;
  bit m_pend, e_ovs, e_bit, e_mid;

  baud_tick_gen #(
    .CNT_W(CNT_W), .DEFAULT_DIV(DEFAULT_DIV), .OVS(OVS), .OVS_W(OVS_W)
  ) dut (
    .clk(clk), .s_reset_n(s_reset_n), .enable(enable), .div_load(div_load),
    .div_value(div_value), .phase_sync(phase_sync), .ovs_tick(ovs_tick),
    .bit_tick(bit_tick), .mid_tick(mid_tick), .div_active(div_active),
    .load_pending(load_pending)
  );

  always #5 clk = ~clk;

  task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic modelStep();
    int cl;
    bit boundary;
    cl = (int'(div_value) < 2) ? 2 : int'(div_value);
    if (!s_reset_n) begin
      m_elapsed = 0; m_ticks = 0; m_div = DEFAULT_DIV; m_shadow = DEFAULT_DIV;
      m_pend = 0; e_ovs = 0; e_bit = 0; e_mid = 0;
    end else if (phase_sync) begin
      if (div_load) begin
        m_shadow = cl;
        m_div = cl;
      end else if (m_pend) begin
        m_div = m_shadow;
      end
      m_pend = 0; m_elapsed = 0; m_ticks = 0; e_ovs = 0; e_bit = 0; e_mid = 0;
    end else begin
      boundary = enable && (m_elapsed + 1 == m_div);
      e_ovs = boundary; e_bit = 0; e_mid = 0;
      if (boundary) begin
        m_ticks++;
        e_bit = (m_ticks % OVS) == 0;
        e_mid = (m_ticks % OVS) == OVS / 2;
        m_elapsed = 0;
      end else if (enable) begin
        m_elapsed++;
      end
      if (div_load) begin
        m_shadow = cl;
        if (boundary) begin
          m_div = cl;
          m_pend = 0;
        end else begin
          m_pend = 1;
        end
      end else if (boundary && m_pend) begin
        m_div = m_shadow;
        m_pend = 0;
      end
    end
  endtask

  task automatic checkOutput();
    checkValue("ovs_tick", 32'(ovs_tick), 32'(e_ovs));
    checkValue("bit_tick", 32'(bit_tick), 32'(e_bit));
    checkValue("mid_tick", 32'(mid_tick), 32'(e_mid));
    checkValue("div_active", 32'(div_active), 32'(m_div));
    checkValue("load_pending", 32'(load_pending), 32'(m_pend));
  endtask

  task automatic applyStimulus(input bit rst_n, input bit en, input bit load,
                               input logic [CNT_W-1:0] val, input bit sync);
    s_reset_n = rst_n; enable = en; div_load = load; div_value = val; phase_sync = sync;
    @(posedge clk);
    modelStep();
    #1;
    checkOutput();
  endtask

  task automatic stepsUntilOvs(output int n);
    n = -1;
    for (int i = 1; i <= 1000; i++) begin
      applyStimulus(1, 1, 0, '0, 0);
      if (ovs_tick === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  initial begin
    int first_ovs, n, k, mid_at, bit_at, ticks_low, en_cnt, bits_seen, cyc;
    int bit_cycs[$];
    int mid_cycs[$];
    bit en, r;

    // Scenario 1: default rates after reset
    applyStimulus(0, 1, 0, '0, 0);
    checkValue("reset_div_active", 32'(div_active), 32'(DEFAULT_DIV));
    checkValue("reset_ovs_tick", 32'(ovs_tick), 32'd0);
    first_ovs = -1;
    for (int i = 1; i <= 7000; i++) begin
      applyStimulus(1, 1, 0, '0, 0);
      if (ovs_tick === 1'b1 && first_ovs < 0) first_ovs = i;
      if (bit_tick === 1'b1) bit_cycs.push_back(i);
      if (mid_tick === 1'b1) mid_cycs.push_back(i);
    end
    checkValue("first_ovs", 32'(first_ovs), 32'd217);
    checkValue("bit_count", 32'(bit_cycs.size()), 32'd2);
    checkValue("mid_count", 32'(mid_cycs.size()), 32'd2);
    if (bit_cycs.size() == 2 && mid_cycs.size() == 2) begin
      checkValue("first_bit", 32'(bit_cycs[0]), 32'd3472);
      checkValue("bit_spacing", 32'(bit_cycs[1] - bit_cycs[0]), 32'd3472);
      checkValue("first_mid", 32'(mid_cycs[0]), 32'd1736);
      checkValue("mid_after_bit", 32'(mid_cycs[1] - bit_cycs[0]), 32'd1736);
    end

    // Scenario 2: load 4 while pcnt=100, current 217-clock period must finish
    applyStimulus(0, 1, 0, '0, 0);
    for (int i = 0; i < 100; i++) applyStimulus(1, 1, 0, '0, 0);
    applyStimulus(1, 1, 1, 16'd4, 0);
    checkValue("pending_after_load", 32'(load_pending), 32'd1);
    stepsUntilOvs(n);
    checkValue("period_not_shortened", 32'(n), 32'd116);
    checkValue("pending_cleared", 32'(load_pending), 32'd0);
    checkValue("div_applied", 32'(div_active), 32'd4);
    stepsUntilOvs(n);
    checkValue("period_4", 32'(n), 32'd4);

    // Scenario 3: clamping of 0 and 1, and load on the rollover edge
    applyStimulus(1, 1, 1, 16'd0, 0);
    stepsUntilOvs(n);
    checkValue("clamp0_div", 32'(div_active), 32'd2);
    stepsUntilOvs(n);
    checkValue("clamp0_period", 32'(n), 32'd2);
    applyStimulus(1, 1, 1, 16'd1, 0);
    checkValue("clamp1_pending", 32'(load_pending), 32'd1);
    stepsUntilOvs(n);
    checkValue("clamp1_div", 32'(div_active), 32'd2);
    applyStimulus(1, 1, 0, '0, 0);
    applyStimulus(1, 1, 1, 16'd3, 0);
    checkValue("rollover_load_pending", 32'(load_pending), 32'd0);
    checkValue("rollover_load_div", 32'(div_active), 32'd3);
    stepsUntilOvs(n);
    checkValue("rollover_load_period", 32'(n), 32'd3);

    // Scenario 4: phase_sync at pcnt=2, ocnt=9 with divisor 4
    applyStimulus(0, 1, 0, '0, 0);
    applyStimulus(1, 1, 1, 16'd4, 1);
    checkValue("sync_load_div", 32'(div_active), 32'd4);
    for (int i = 0; i < 38; i++) applyStimulus(1, 1, 0, '0, 0);
    applyStimulus(1, 1, 0, '0, 1);
    checkValue("sync_no_tick", 32'(ovs_tick), 32'd0);
    k = 0; mid_at = -1; bit_at = -1; first_ovs = -1;
    for (int i = 1; i <= 200; i++) begin
      applyStimulus(1, 1, 0, '0, 0);
      if (ovs_tick === 1'b1) begin
        k++;
        if (first_ovs < 0) first_ovs = i;
      end
      if (mid_tick === 1'b1 && mid_at < 0) mid_at = k;
      if (bit_tick === 1'b1) begin
        bit_at = k;
        break;
      end
    end
    checkValue("sync_first_ovs", 32'(first_ovs), 32'd4);
    checkValue("sync_mid_index", 32'(mid_at), 32'd8);
    checkValue("sync_bit_index", 32'(bit_at), 32'd16);

    // Scenario 5: freeze for 10 clocks at pcnt=1
    applyStimulus(1, 1, 0, '0, 0);
    ticks_low = 0;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1, 0, 0, '0, 0);
      if (ovs_tick !== 1'b0 || bit_tick !== 1'b0 || mid_tick !== 1'b0) ticks_low++;
    end
    checkValue("ticks_while_disabled", 32'(ticks_low), 32'd0);
    stepsUntilOvs(n);
    checkValue("resume_period", 32'(n), 32'(4 - 1));
    bits_seen = 0; en_cnt = 0;
    for (int i = 0; i < 2000 && bits_seen < 2; i++) begin
      en = ($urandom_range(0, 3) != 0);
      applyStimulus(1, en, 0, '0, 0);
      if (bits_seen == 1 && en) en_cnt++;
      if (bit_tick === 1'b1) bits_seen++;
    end
    checkValue("bits_seen_gated", 32'(bits_seen), 32'd2);
    checkValue("bit_spacing_enabled", 32'(en_cnt), 32'd64);

    // Scenario 6: one-cycle reset mid-bit while a load is pending
    applyStimulus(1, 1, 1, 16'd9, 0);
    checkValue("pending_before_reset", 32'(load_pending), 32'd1);
    applyStimulus(0, 1, 0, '0, 0);
    checkValue("reset_pending", 32'(load_pending), 32'd0);
    checkValue("reset_div", 32'(div_active), 32'd217);
    checkValue("reset_bit", 32'(bit_tick), 32'd0);
    stepsUntilOvs(n);
    checkValue("restart_first_ovs", 32'(n), 32'd217);

    // Random traffic against the model
    cyc = 0;
    for (int i = 0; i < 4000; i++) begin
      r = ($urandom_range(0, 399) != 0);
      if ($urandom_range(0, 9) == 0)
        applyStimulus(r, $urandom_range(0, 4) != 0, $urandom_range(0, 39) == 0,
                      CNT_W'($urandom_range(0, 1)), $urandom_range(0, 79) == 0);
      else
        applyStimulus(r, $urandom_range(0, 4) != 0, $urandom_range(0, 39) == 0,
                      CNT_W'($urandom_range(2, 12)), $urandom_range(0, 79) == 0);
      cyc++;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
